uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 Parameter PRESCALE, default 32, maximum supported clock cycles per bit; sets Prescale port width.
REQ-003 CLK  input  1  single system clock, all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 P_Data  input  DATA_WIDTH  parallel word to transmit.
REQ-006 Data_Valid  input  1  request strobe, qualifies P_Data for one cycle.
REQ-007 PAR_EN  input  1  1 = parity bit inserted after data.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 Prescale  input  $clog2(PRESCALE)+1  clock cycles per bit, legal range 1..PRESCALE.
REQ-010 TX_OUT  output  1  serial line, idle high.
REQ-011 Busy  output  1  high while a frame is in progress.

Function
REQ-012 Frame format SHALL be: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-014 In IDLE with Data_Valid=1, the block SHALL latch P_Data, PAR_EN, PAR_TYP and Prescale and go to START next cycle.
REQ-015 Data_Valid SHALL be ignored in every state other than IDLE; the latched frame SHALL be unaffected by input changes mid-frame.
REQ-016 TX_OUT SHALL go to 0 and Busy to 1 on the first cycle after acceptance (1-cycle latency).
REQ-017 Each bit SHALL be driven for exactly the latched Prescale cycles, counted by an edge counter 0..Prescale-1; Prescale=0 SHALL be treated as 1.
REQ-018 A bit counter SHALL select data bit index 0..DATA_WIDTH-1 in DATA; DATA leaves after the last cycle of bit DATA_WIDTH-1.
REQ-019 DATA SHALL go to PARITY when latched PAR_EN=1, else to STOP.
REQ-020 Parity bit SHALL be XOR of latched data for even, inverted XOR for odd.
REQ-021 STOP SHALL drive 1 for Prescale cycles, then go to IDLE; Busy SHALL be 0 from the first IDLE cycle.
REQ-022 Data_Valid in the first IDLE cycle after STOP SHALL be accepted (back-to-back frames, one idle-high cycle between stop and next start).
REQ-023 Total Busy-high duration SHALL be (DATA_WIDTH+2+PAR_EN)*Prescale cycles.
REQ-024 TX_OUT SHALL be 1 in IDLE at all times.

Reset
REQ-025 While RST=0 at a rising edge: state IDLE, TX_OUT=1, Busy=0, counters and latched registers 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame at the next edge; no partial bits resume after release.
REQ-027 First Data_Valid accepted SHALL be in the first cycle with RST=1.

Verification
REQ-028 Prescale=1, PAR_EN=1, PAR_TYP=0, P_Data=0xA5 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1; Busy high 11 cycles.
REQ-029 Prescale=8, PAR_EN=0, P_Data=0x3C -> each bit held 8 cycles, sequence 0,0,0,1,1,1,1,0,0,1; Busy high 80 cycles.
REQ-030 Prescale=1, PAR_EN=1, PAR_TYP=1, P_Data=0x01 -> parity bit 0; P_Data=0x00 -> parity bit 1.
REQ-031 Data_Valid pulsed with P_Data=0xFF during a 0x55 frame -> 0x55 frame unchanged, 0xFF never sent.
REQ-032 Data_Valid held high continuously, Prescale=4 -> frames repeat with exactly one idle-high cycle between stop and start.
REQ-033 RST=0 during DATA bit 3 -> next cycle TX_OUT=1, Busy=0; new frame after release transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit. Each bit lasts Prescale clock cycles.
module uart_tx #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned PRESCALE   = 32,
  localparam int unsigned PW         = $clog2(PRESCALE) + 1,
  localparam int unsigned BW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PW-1:0]         Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [PW-1:0]         edge_cnt;
  logic [PW-1:0]         presc_r;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;

  logic                  bit_done;
  logic                  last_bit;
  logic [BW-1:0]         bit_nxt;
  logic                  par_bit;
  logic [PW-1:0]         presc_eff;

  // Bit timing and frame helpers derived from the latched frame
  assign bit_done  = (edge_cnt == presc_r - PW'(1));
  assign last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign bit_nxt   = bit_cnt + BW'(1);
  assign par_bit   = (^data_r) ^ par_typ_r;
  assign presc_eff = (Prescale == '0) ? PW'(1) : Prescale;

  // Frame FSM with registered line and busy outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      presc_r   <= '0;
      bit_cnt   <= '0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (Data_Valid) begin
            data_r    <= P_Data;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            presc_r   <= presc_eff;
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            TX_OUT   <= data_r[0];
          end else begin
            edge_cnt <= edge_cnt + PW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            edge_cnt <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              if (par_en_r) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_nxt;
              TX_OUT  <= data_r[bit_nxt];
            end
          end else begin
            edge_cnt <= edge_cnt + PW'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= STOP;
            TX_OUT   <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + PW'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            edge_cnt <= '0;
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
          end else begin
            edge_cnt <= edge_cnt + PW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
